// File: rtl/pl_nn_pkg.sv
// Shared PL_NN sequencer types and width helpers, also imported by the AXI
// front end so it can gate BRAM writes on the sequencer state.
package pl_nn_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    DRAIN  = 3'd3,
    STREAM = 3'd4,
    DONE   = 3'd5
  } seq_state_t;

  // Counter width for n distinct values, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N_OUT_DEF   = 10;
  localparam int SEL_W_DEF   = cnt_w(N_OUT_DEF);
  localparam int SEQ_STATE_W = 3;

endpackage

// File: rtl/nn_inference_sequencer_if.sv
// Output AXI-Stream carrying one accumulator value per perceptron.
interface nn_inference_sequencer_if #(
  parameter int DATA_W = 32
);

  logic [DATA_W-1:0] a_tdata;
  logic              a_tvalid;
  logic              a_tready;
  logic              a_tlast;

  modport master (output a_tdata, output a_tvalid, output a_tlast, input a_tready);
  modport slave  (input a_tdata, input a_tvalid, input a_tlast, output a_tready);

endinterface

// File: rtl/nn_valid_delay.sv
// Delays the BRAM read enable by the BRAM latency so the MACs consume data
// exactly when it appears. Shifts continuously; only reset clears it.
module nn_valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] shift_r;

  // Shift register, new sample enters at bit 0.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      shift_r <= '0;
    end else begin
      shift_r <= (shift_r << 1) | DEPTH'(din);
    end
  end

  assign dout = shift_r[DEPTH-1];

endmodule

// File: rtl/nn_inference_sequencer.sv
// Sequences one inference: clear MACs, feed every image pixel, wait for the
// MAC pipeline to drain, then stream one beat per perceptron accumulator.
module nn_inference_sequencer
  import pl_nn_pkg::*;
#(
  parameter  int N_INPUTS = 784,
  parameter  int N_OUT    = 10,
  parameter  int ADDR_W   = 12,
  parameter  int DATA_W   = 32,
  parameter  int BRAM_LAT = 1,
  parameter  int MAC_LAT  = 2,
  localparam int SEL_W    = cnt_w(N_OUT),
  localparam int DRN_W    = $clog2(BRAM_LAT + MAC_LAT + 1)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      bram_en,
  output logic [ADDR_W-1:0]         bram_addr,
  output logic                      mac_clear,
  output logic                      mac_en,
  output logic [SEL_W-1:0]          acc_sel,
  input  logic [DATA_W-1:0]         acc_data,
  nn_inference_sequencer_if.master  a_if
);

  seq_state_t        state_r, state_s;
  logic              start_q_r;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [SEL_W-1:0]  idx_r, idx_s;
  logic [DRN_W-1:0]  drain_r, drain_s;
  logic              launch_s;
  logic              busy_s, done_s, bram_en_s, mac_clear_s, tvalid_s, tlast_s;
  logic [ADDR_W-1:0] bram_addr_s;
  logic [SEL_W-1:0]  acc_sel_s;

  // Only a rising start seen while idle launches; a held level launches once.
  assign launch_s = start & ~start_q_r & (state_r == IDLE);

  // State, counters and start edge detector.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r   <= IDLE;
      start_q_r <= 1'b0;
      addr_r    <= '0;
      idx_r     <= '0;
      drain_r   <= '0;
    end else begin
      state_r   <= state_s;
      start_q_r <= start;
      addr_r    <= addr_s;
      idx_r     <= idx_s;
      drain_r   <= drain_s;
    end
  end

  // Next-state, counter updates and Moore-decoded outputs.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    idx_s       = idx_r;
    drain_s     = drain_r;
    busy_s      = 1'b1;
    done_s      = 1'b0;
    bram_en_s   = 1'b0;
    bram_addr_s = '0;
    mac_clear_s = 1'b0;
    tvalid_s    = 1'b0;
    tlast_s     = 1'b0;
    acc_sel_s   = '0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        if (launch_s) begin
          state_s = CLEAR;
        end else begin
          state_s = IDLE;
        end
      end
      CLEAR: begin
        mac_clear_s = 1'b1;
        addr_s      = '0;
        state_s     = FEED;
      end
      FEED: begin
        bram_en_s   = 1'b1;
        bram_addr_s = addr_r;
        if (addr_r == ADDR_W'(N_INPUTS - 1)) begin
          drain_s = DRN_W'(BRAM_LAT + MAC_LAT - 1);
          state_s = DRAIN;
        end else begin
          addr_s = addr_r + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (drain_r == DRN_W'(0)) begin
          idx_s   = '0;
          state_s = STREAM;
        end else begin
          drain_s = drain_r - DRN_W'(1);
        end
      end
      STREAM: begin
        // Selection holds while stalled so the muxed accumulator stays stable.
        tvalid_s  = 1'b1;
        acc_sel_s = idx_r;
        tlast_s   = (idx_r == SEL_W'(N_OUT - 1));
        if (a_if.a_tready) begin
          if (tlast_s) begin
            state_s = DONE;
          end else begin
            idx_s = idx_r + SEL_W'(1);
          end
        end else begin
          idx_s = idx_r;
        end
      end
      DONE: begin
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  nn_valid_delay #(.DEPTH(BRAM_LAT)) u_valid_delay (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .din    (bram_en_s),
    .dout   (mac_en)
  );

  assign busy          = busy_s;
  assign done          = done_s;
  assign bram_en       = bram_en_s;
  assign bram_addr     = bram_addr_s;
  assign mac_clear     = mac_clear_s;
  assign acc_sel       = acc_sel_s;
  assign a_if.a_tvalid = tvalid_s;
  assign a_if.a_tlast  = tlast_s;
  assign a_if.a_tdata  = acc_data;

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Cycle-level check of the inference sequencer against a timeline model
// built from launch time, beats handed over and the done cycle.
module tb_nn_inference_sequencer;

  localparam int N_INPUTS = 8;
  localparam int N_OUT    = 3;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int BRAM_LAT = 1;
  localparam int MAC_LAT  = 2;
  localparam int T_STREAM = N_INPUTS + 2 + BRAM_LAT + MAC_LAT;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic              start;
  logic              busy, done, bram_en, mac_clear, mac_en;
  logic [ADDR_W-1:0] bram_addr;
  logic [1:0]        acc_sel;
  logic [DATA_W-1:0] acc_data;
  logic [DATA_W-1:0] acc_vals [4];

  nn_inference_sequencer_if #(.DATA_W(DATA_W)) a_if ();

  nn_inference_sequencer #(
    .N_INPUTS (N_INPUTS),
    .N_OUT    (N_OUT),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BRAM_LAT (BRAM_LAT),
    .MAC_LAT  (MAC_LAT)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .bram_en   (bram_en),
    .bram_addr (bram_addr),
    .mac_clear (mac_clear),
    .mac_en    (mac_en),
    .acc_sel   (acc_sel),
    .acc_data  (acc_data),
    .a_if      (a_if)
  );

  always #5 ACLK = ~ACLK;

  assign acc_data = acc_vals[acc_sel];

  // Model: cycles since launch (0 = idle), beats handed over, done cycle flag.
  int m_t = 0;
  int m_beats = 0;
  bit m_fin = 1'b0;
  bit m_prev = 1'b0;
  bit hist [BRAM_LAT];

  bit e_busy, e_done, e_clear, e_en, e_valid, e_last, e_mac;
  int e_addr, e_sel;
  logic [DATA_W-1:0] e_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [DATA_W-1:0] beat_q [$];
  bit last_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic calc();
    e_busy  = (m_t > 0);
    e_done  = m_fin;
    e_clear = (m_t == 1);
    e_en    = (m_t >= 2) && (m_t <= N_INPUTS + 1);
    e_addr  = e_en ? m_t - 2 : 0;
    e_valid = (m_t >= T_STREAM) && !m_fin;
    e_sel   = e_valid ? m_beats : 0;
    e_last  = e_valid && (m_beats == N_OUT - 1);
    e_mac   = hist[BRAM_LAT-1];
    e_data  = acc_vals[e_sel];
  endtask

  task automatic update();
    bit launch;
    if (ARESET) begin
      m_t = 0; m_beats = 0; m_fin = 1'b0; m_prev = 1'b0;
      for (int i = 0; i < BRAM_LAT; i++) hist[i] = 1'b0;
    end else begin
      for (int i = BRAM_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = e_en;
      launch = start && !m_prev && (m_t == 0);
      m_prev = start;
      if (m_fin) begin
        m_t = 0; m_fin = 1'b0; m_beats = 0;
      end else if (m_t > 0) begin
        if (e_valid && a_if.a_tready) begin
          if (m_beats == N_OUT - 1) m_fin = 1'b1;
          else m_beats++;
        end
        m_t++;
      end else if (launch) begin
        m_t = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    update();
    #1;
    calc();
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("mac_clear", mac_clear, e_clear);
    chk("bram_en", bram_en, e_en);
    chk("bram_addr", bram_addr, e_addr);
    chk("mac_en", mac_en, e_mac);
    chk("tvalid", a_if.a_tvalid, e_valid);
    chk("tlast", a_if.a_tlast, e_last);
    chk("acc_sel", acc_sel, e_sel);
    chk("tdata", a_if.a_tdata, e_data);
    if (done === 1'b1) done_cnt++;
    if (a_if.a_tvalid === 1'b1 && a_if.a_tready === 1'b1) begin
      beat_q.push_back(a_if.a_tdata);
      last_q.push_back(a_if.a_tlast);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < BRAM_LAT; i++) hist[i] = 1'b0;
    acc_vals[0] = 32'h11; acc_vals[1] = 32'h22; acc_vals[2] = 32'h33; acc_vals[3] = 32'h0;
    ARESET = 1'b1; start = 1'b0; a_if.a_tready = 1'b1;
    tick(); tick();
    ARESET = 1'b0;
    tick(); tick();

    // Basic run with distinct accumulator values.
    done_cnt = 0; beat_q.delete(); last_q.delete();
    pulse_start();
    for (int i = 0; i < 20; i++) tick();
    chk("s1_done_cnt", done_cnt, 1);
    chk("s1_beats", beat_q.size(), 3);
    for (int i = 0; i < beat_q.size(); i++) begin
      chk("s1_beat_data", beat_q[i], 32'h11 * (i + 1));
      chk("s1_beat_last", last_q[i], (i == 2) ? 1 : 0);
    end

    // Stall the first beat for 4 cycles.
    acc_vals[0] = $urandom; acc_vals[1] = $urandom; acc_vals[2] = $urandom;
    done_cnt = 0;
    pulse_start();
    for (int i = 0; i < 12; i++) tick();
    a_if.a_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s2_stall_data", a_if.a_tdata, acc_vals[0]);
    end
    a_if.a_tready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("s2_done_cnt", done_cnt, 1);

    // Held start launches once; a fresh edge launches again.
    done_cnt = 0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) tick();
    chk("s3_held_done_cnt", done_cnt, 1);
    start = 1'b0;
    tick(); tick();
    pulse_start();
    for (int i = 0; i < 20; i++) tick();
    chk("s3_relaunch_done_cnt", done_cnt, 2);

    // Start edges during FEED and during DONE are ignored.
    done_cnt = 0; beat_q.delete(); last_q.delete();
    pulse_start();
    for (int i = 0; i < 25; i++) begin
      start = (i == 4 || e_done) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("s4_done_cnt", done_cnt, 1);
    chk("s4_beats", beat_q.size(), 3);

    // Reset in the middle of FEED aborts without done.
    done_cnt = 0;
    pulse_start();
    for (int i = 0; i < 4; i++) tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("s5_abort_done_cnt", done_cnt, 0);
    pulse_start();
    for (int i = 0; i < 20; i++) tick();
    chk("s5_clean_done_cnt", done_cnt, 1);

    // Randomised start, backpressure, data and occasional reset.
    for (int i = 0; i < 400; i++) begin
      start         = ($urandom_range(0, 5) == 0);
      a_if.a_tready = ($urandom_range(0, 2) != 0);
      ARESET        = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 9) == 0) acc_vals[$urandom_range(0, 2)] = $urandom;
      tick();
    end
    ARESET = 1'b0; start = 1'b0; a_if.a_tready = 1'b1;
    for (int i = 0; i < 25; i++) tick();
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
